// File: rtl/fetch_pkg.sv
// Shared constants, field positions and FSM state type for the instruction fetch stage.
package fetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int ADDR_W   = 32;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;
  localparam int FUNC_MSB = 29;
  localparam int FUNC_LSB = 25;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP_DEF  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's pipeline control, instruction-memory and decode-side signals.
interface fetch_stage_if;
  import fetch_pkg::*;

  // if_valid qualifies if_instr/if_pc; decode takes the word in any cycle with
  // if_valid && !stall, and while stall is high the fetch outputs hold steady.
  logic                               stall;
  logic                               redirect;
  logic [ADDR_W-1:0]                  redirect_pc;
  logic                               imem_req;
  logic [ADDR_W-1:0]                  imem_addr;
  logic [INSTR_W-1:0]                 imem_rdata;
  logic                               if_valid;
  logic [INSTR_W-1:0]                 if_instr;
  logic [ADDR_W-1:0]                  if_pc;
  logic [TYPE_MSB-TYPE_LSB:0]         instruction_type;
  logic [FUNC_MSB-FUNC_LSB:0]         func;
  fetch_state_t                       dbg_state;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
           instruction_type, func, dbg_state
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
           instruction_type, func, dbg_state
  );
endinterface

// File: rtl/skid_buffer.sv
// One-entry instruction/PC holding register used when decode stalls with a read in flight.
module skid_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_drain,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // Clear beats load so a redirect always empties the buffer; load beats drain
  // so a drain and refill in the same edge keeps the entry valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, one-cycle instruction memory, stall skid and branch redirect flush.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_inflight;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic               w_req;
  logic               w_run;
  logic               w_skid_load;
  logic               w_skid_drain;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0]  w_skid_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // A stalled read that returns must have somewhere to land, so requests stop
  // while stalled with a read in flight or the skid already holding a word.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      IDLE:    w_state_next = RUN;
      RUN:     w_req = !(bus.stall && (r_inflight || w_skid_valid));
      FLUSH: begin
        w_req        = 1'b1;
        w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
    if (bus.redirect) w_state_next = FLUSH;
  end

  assign w_run        = (r_state == RUN) && !bus.redirect;
  assign w_skid_load  = w_run && r_inflight && (bus.stall || w_skid_valid);
  assign w_skid_drain = w_run && !bus.stall && w_skid_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_req_pc <= r_pc;
      if (bus.redirect) r_pc <= bus.redirect_pc;
      else if (w_req)   r_pc <= r_pc + PC_STEP;
    end
  end

  // Outside RUN any returning read belongs to a flushed path and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else if (bus.redirect || (r_state != RUN)) begin
      r_if_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (w_skid_valid) begin
        r_if_valid <= 1'b1;
        r_if_instr <= w_skid_instr;
        r_if_pc    <= w_skid_pc;
      end else if (r_inflight) begin
        r_if_valid <= 1'b1;
        r_if_instr <= bus.imem_rdata;
        r_if_pc    <= r_req_pc;
      end else begin
        r_if_valid <= 1'b0;
      end
    end
  end

  skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (bus.redirect),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_instr (bus.imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  assign bus.imem_req         = w_req;
  assign bus.imem_addr        = r_pc;
  assign bus.if_valid         = r_if_valid;
  assign bus.if_instr         = r_if_instr;
  assign bus.if_pc            = r_if_pc;
  assign bus.instruction_type = r_if_instr[TYPE_MSB:TYPE_LSB];
  assign bus.func             = r_if_instr[FUNC_MSB:FUNC_LSB];
  assign bus.dbg_state        = r_state;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios, then random stall/redirect traffic against a program-order model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          errors = 0;
  int          checks = 0;
  int          consumed = 0;
  int          drained = 0;
  logic [31:0] exp_q[$];
  logic        s;
  logic        r;
  logic [31:0] tgt;
  logic [31:0] e;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address, one planted opcode.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h4800_0000;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  // One-cycle registered read.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= word_of(bus.imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_pc"}, bus.if_pc, pc);
      chk({tag, "_instr"}, bus.if_instr, word_of(pc));
    end
  endtask

  // Advance to the middle of the next cycle with the given inputs applied.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rp);
    @(posedge clk);
    #1;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    @(negedge clk);
  endtask

  // Leaves the bench mid-way through cycle 0 (the cycle in which reset releases).
  task automatic reset_dut();
    rst             = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset release, free-running stream.
    reset_dut();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    cyc(0, 0, 0);
    chk("c1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 0);
    chk_out("c2", 1'b0, 32'h0);
    cyc(0, 0, 0);
    chk_out("c3", 1'b1, 32'h0);
    cyc(0, 0, 0);
    chk_out("c4", 1'b1, 32'h4);
    cyc(0, 0, 0);
    chk_out("c5", 1'b1, 32'h8);

    // Three-cycle stall mid-stream.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk_out("stall_hold", 1'b1, 32'hC);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    cyc(0, 0, 0);
    chk_out("stall_rel", 1'b1, 32'hC);
    chk("stall_rel_addr", bus.imem_addr, 32'h14);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      chk_out("stall_after", 1'b1, 32'h10 + 32'(k) * 32'd4);
    end

    // Redirect to 0x40 while the word at 0x10 is in flight.
    reset_dut();
    repeat (5) cyc(0, 0, 0);
    cyc(0, 1, 32'h40);
    chk_out("redir_c6", 1'b1, 32'hC);
    cyc(0, 0, 0);
    chk_out("redir_c7", 1'b0, 32'h0);
    chk("redir_c7_addr", bus.imem_addr, 32'h40);
    chk("redir_c7_state", 32'(bus.dbg_state), 32'(FLUSH));
    cyc(0, 0, 0);
    chk_out("redir_c8", 1'b0, 32'h0);
    cyc(0, 0, 0);
    chk_out("redir_c9", 1'b1, 32'h40);
    cyc(0, 0, 0);
    chk_out("redir_c10", 1'b1, 32'h44);

    // Redirect and stall together with the skid full.
    reset_dut();
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk_out("rs_c6", 1'b1, 32'hC);
    cyc(1, 1, 32'h80);
    chk_out("rs_c7", 1'b1, 32'hC);
    chk("rs_c7_req", {31'd0, bus.imem_req}, 32'd0);
    cyc(0, 0, 0);
    chk_out("rs_c8", 1'b0, 32'h0);
    chk("rs_c8_addr", bus.imem_addr, 32'h80);
    cyc(0, 0, 0);
    chk_out("rs_c9", 1'b0, 32'h0);
    cyc(0, 0, 0);
    chk_out("rs_c10", 1'b1, 32'h80);
    cyc(0, 0, 0);
    chk_out("rs_c11", 1'b1, 32'h84);

    // PC wrap at the top of the address space.
    reset_dut();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 32'hFFFF_FFF8);
    repeat (3) cyc(0, 0, 0);
    chk_out("wrap_c6", 1'b1, 32'hFFFF_FFF8);
    chk("wrap_c6_addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 0);
    chk_out("wrap_c7", 1'b1, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk_out("wrap_c8", 1'b1, 32'h0);

    // Decode fields, then asynchronous reset during a stall.
    reset_dut();
    cyc(0, 1, 32'h100);
    repeat (3) cyc(0, 0, 0);
    chk_out("dec", 1'b1, 32'h100);
    chk("dec_type", {30'd0, bus.instruction_type}, 32'd1);
    chk("dec_func", {27'd0, bus.func}, 32'd4);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("arst_instr", bus.if_instr, 32'd0);
    chk("arst_pc", bus.if_pc, 32'd0);
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_type", {30'd0, bus.instruction_type}, 32'd0);
    chk("arst_func", {27'd0, bus.func}, 32'd0);
    chk("arst_state", 32'(bus.dbg_state), 32'(IDLE));
    bus.stall = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_out("post_c0", 1'b0, 32'h0);
    cyc(0, 0, 0);
    chk_out("post_c1", 1'b0, 32'h0);
    cyc(0, 0, 0);
    chk_out("post_c2", 1'b0, 32'h0);
    cyc(0, 0, 0);
    chk_out("post_c3", 1'b1, 32'h0);

    // Random stall/redirect traffic: accepted words must follow program order.
    reset_dut();
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        1:       tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      cyc(s, r, tgt);
      if (r) begin
        exp_q.delete();
        exp_q.push_back(tgt);
      end else if (bus.if_valid && !s) begin
        e = exp_q.pop_front();
        chk("rnd_pc", bus.if_pc, e);
        chk("rnd_instr", bus.if_instr, word_of(e));
        exp_q.push_back(e + 32'd4);
        consumed++;
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0);
      if (bus.if_valid) begin
        e = exp_q.pop_front();
        chk("drain_pc", bus.if_pc, e);
        chk("drain_instr", bus.if_instr, word_of(e));
        exp_q.push_back(e + 32'd4);
        drained++;
      end
    end
    chk("rnd_progress", {31'd0, consumed > 200}, 32'd1);
    chk("drain_progress", {31'd0, drained >= 8}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  in  1  decode/execute cannot accept; hold outputs.
REQ-006 SHALL have port redirect  in  1  taken branch (brinco/igual/leq/geq resolved); flush and refetch.
REQ-007 SHALL have port redirect_pc  in  32  branch target byte address.
REQ-008 SHALL have port imem_req  out  1  instruction memory read strobe.
REQ-009 SHALL have port imem_addr  out  32  read address, equal to PC register.
REQ-010 SHALL have port imem_rdata  in  32  read data, valid the cycle after imem_req sampled high.
REQ-011 SHALL have port if_valid  out  1  if_instr/if_pc hold a live instruction.
REQ-012 SHALL have port if_instr  out  32  fetched instruction word.
REQ-013 SHALL have port if_pc  out  32  address of if_instr.
REQ-014 SHALL have port instruction_type  out  2  if_instr[31:30], feeds control unit.
REQ-015 SHALL have port func  out  5  if_instr[29:25], feeds control unit.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FLUSH; IDLE->RUN on first edge after rst release.
REQ-017 SHALL in RUN drive imem_req = !(stall && (inflight || skid_valid)), and advance PC by PC_STEP on every issued request.
REQ-018 SHALL set inflight on the edge where imem_req is high, clear it otherwise; rdata is consumed in the inflight cycle.
REQ-019 SHALL, when !stall, load outputs from skid if skid_valid, else from imem_rdata if inflight, else drive if_valid=0.
REQ-020 SHALL, when skid drains while inflight, move the new imem_rdata into skid in the same edge.
REQ-021 SHALL, when stall and inflight, capture imem_rdata and its PC into the 1-entry skid; outputs unchanged.
REQ-022 SHALL never overflow skid; stall with skid_valid blocks any request.
REQ-023 SHALL, on redirect (any state, overrides stall), load PC<=redirect_pc, clear skid_valid, clear if_valid, enter FLUSH.
REQ-024 SHALL in FLUSH discard imem_rdata of the old path, issue imem_req at redirect_pc, go to RUN next edge.
REQ-025 SHALL accept a new redirect in FLUSH, reloading PC and staying in FLUSH.
REQ-026 SHALL give latency: request cycle N -> if_valid with that word in cycle N+2.
REQ-027 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
REQ-028 SHALL derive instruction_type/func combinationally from if_instr, don't-care when if_valid=0.

Reset
REQ-029 SHALL on rst low asynchronously force state=IDLE, PC=RESET_PC, inflight=0, skid_valid=0, if_valid=0, if_instr=0, if_pc=0, imem_req=0.
REQ-030 SHALL discard any in-flight read when reset asserts mid-operation; no output after release until a new request returns.

Structure
REQ-031 SHALL take RESET_PC default, PC_STEP, INSTR_W=32, field positions TYPE_MSB/LSB, FUNC_MSB/LSB and the state enum from shared package fetch_pkg.
REQ-032 SHALL place the 1-entry instruction/PC buffer in sub-module skid_buffer.

Verification
REQ-033 SHALL test reset release, no stall: imem_req at 0x0 cycle 1, if_valid=1 with if_pc=0x0 cycle 3, then 0x4, 0x8 each cycle.
REQ-034 SHALL test stall held 3 cycles mid-stream: if_pc frozen, exactly one word captured in skid, imem_req low; on release words emerge in order, none lost or duplicated.
REQ-035 SHALL test redirect to 0x40 with word 0x10 in flight: 0x10 never appears, if_valid=0 for 2 cycles, then if_pc=0x40, 0x44.
REQ-036 SHALL test redirect and stall same cycle, skid full: skid cleared, next valid output is redirect_pc.
REQ-037 SHALL test PC=0xFFFF_FFFC sequential fetch: next if_pc=0x0.
REQ-038 SHALL test instruction 32'h4800_0000 presented: instruction_type=2'b01, func=5'b00100; rst low mid-stall: all outputs zero immediately.
